cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 126 ++++++++++++
 tb/tb_cache_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cache port among NREQ requesters, one transaction in flight.
// Optional watchdog on the cache response is enabled by defining ARB_TIMEOUT_EN.
module cache_arbiter #(
    parameter int NREQ     = 2,
    parameter int ADDRBITS = 32,
    parameter int WORDBITS = 32,
    parameter int TIMEOUT  = 255
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NREQ-1:0]                    req,
    input  logic [NREQ-1:0]                    rw,
    input  logic [NREQ-1:0][ADDRBITS-1:0]      addr,
    input  logic [NREQ-1:0][WORDBITS-1:0]      wdata,
    output logic [NREQ-1:0]                    valid,
    output logic [NREQ-1:0]                    err,
    output logic [WORDBITS-1:0]                rdata,
    output logic                               cache_request,
    output logic                               cache_rw,
    output logic [ADDRBITS-1:0]                cache_addr,
    output logic [WORDBITS-1:0]                cache_wdata,
    input  logic                               cache_valid,
    input  logic [WORDBITS-1:0]                cache_rdata
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   win;
    logic            any_req;
    logic [NREQ-1:0] idx_hot;
    int              cand;

    // Search from last_grant+1 upward; the first requester found wins.
    always_comb begin
        win     = '0;
        any_req = 1'b0;
        cand    = 0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(last_grant) + i) % NREQ;
            if (!any_req && req[cand]) begin
                win     = IW'(cand);
                any_req = 1'b1;
            end
        end
    end

    assign idx_hot = {{(NREQ-1){1'b0}}, 1'b1} << idx;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
`else
    assign err = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= IW'(NREQ - 1);
            idx           <= '0;
            valid         <= '0;
            rdata         <= '0;
            cache_request <= 1'b0;
            cache_rw      <= 1'b0;
            cache_addr    <= '0;
            cache_wdata   <= '0;
`ifdef ARB_TIMEOUT_EN
            err           <= '0;
            cnt           <= '0;
`endif
        end else begin
            valid <= '0;
`ifdef ARB_TIMEOUT_EN
            err   <= '0;
`endif
            case (state)
                IDLE: begin
                    if (any_req) begin
                        idx           <= win;
                        cache_rw      <= rw[win];
                        cache_addr    <= addr[win];
                        cache_wdata   <= wdata[win];
                        cache_request <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    cache_request <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                    cnt           <= '0;
`endif
                    state         <= WAIT;
                end
                WAIT: begin
                    if (cache_valid) begin
                        rdata <= cache_rw ? '0 : cache_rdata;
                        valid <= idx_hot;
                        state <= DONE;
                    end
`ifdef ARB_TIMEOUT_EN
                    // The transition edge is the one on which the count would reach TIMEOUT.
                    else if (cnt == CW'(TIMEOUT - 1)) begin
                        rdata <= '0;
                        valid <= idx_hot;
                        err   <= idx_hot;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
`endif
                end
                DONE: begin
                    last_grant <= idx;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_cache_arbiter;

    localparam int NREQ = 4;
    localparam int AB   = 32;
    localparam int WB   = 32;
    localparam int TO   = 4;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NREQ-1:0]          req = '0;
    logic [NREQ-1:0]          rw = '0;
    logic [NREQ-1:0][AB-1:0]  addr;
    logic [NREQ-1:0][WB-1:0]  wdata;
    logic [NREQ-1:0]          valid;
    logic [NREQ-1:0]          err;
    logic [WB-1:0]            rdata;
    logic                     cache_request;
    logic                     cache_rw;
    logic [AB-1:0]            cache_addr;
    logic [WB-1:0]            cache_wdata;
    logic                     cache_valid = 1'b0;
    logic [WB-1:0]            cache_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    cache_arbiter #(.NREQ(NREQ), .ADDRBITS(AB), .WORDBITS(WB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
        .valid(valid), .err(err), .rdata(rdata),
        .cache_request(cache_request), .cache_rw(cache_rw), .cache_addr(cache_addr),
        .cache_wdata(cache_wdata), .cache_valid(cache_valid), .cache_rdata(cache_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] rw;
        logic            cv;
        logic [WB-1:0]   crd;
        logic            e_creq;
        logic [AB-1:0]   e_addr;
        logic            e_rw;
        logic [NREQ-1:0] e_valid;
        logic [WB-1:0]   e_rdata;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Holds reset low across one rising edge and checks every output is cleared.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        cache_valid = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(valid), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_rdata", 64'(rdata), 64'h0);
        chk("rst_creq", 64'(cache_request), 64'h0);
        chk("rst_crw", 64'(cache_rw), 64'h0);
        chk("rst_caddr", 64'(cache_addr), 64'h0);
        chk("rst_cwdata", 64'(cache_wdata), 64'h0);
        rst_n = 1'b1;
    endtask

    // Waits for the issue cycle, answers after 'delay' WAIT cycles (or never), returns the DONE-cycle outputs.
    task automatic run_txn(input int delay, input bit respond, input logic [WB-1:0] resp,
                           output logic [NREQ-1:0] v, output logic [NREQ-1:0] e,
                           output logic [WB-1:0] rd, output logic [AB-1:0] a);
        bit got = 1'b0;
        int n_wait;
        v = '0; e = '0; rd = '0; a = '0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = cache_request;
        end
        chk("issue_seen", 64'(got), 64'h1);
        if (!got) return;
        a = cache_addr;
        n_wait = respond ? delay + 1 : TO;
        for (int k = 0; k < n_wait; k++) begin
            @(negedge clk);
            cache_valid = respond && (k == delay);
            cache_rdata = resp;
            chk("wait_addr_stable", 64'(cache_addr), 64'(a));
            chk("wait_no_valid", 64'(valid), 64'h0);
        end
        @(negedge clk);
        cache_valid = 1'b0;
        v = valid; e = err; rd = rdata;
        chk("done_addr_stable", 64'(cache_addr), 64'(a));
    endtask

    initial begin
        logic [NREQ-1:0] v, e;
        logic [WB-1:0]   rd;
        logic [AB-1:0]   a;
        logic [NREQ-1:0] one;

        for (int i = 0; i < NREQ; i++) begin
            addr[i]  = 32'h1000 + 32'(i) * 32'h100;
            wdata[i] = 32'hD000 + 32'(i);
        end

        //          req      rw       cv    crd           creq  addr        rw    valid    rdata
        tbl[0]  = '{4'b0011, 4'b0010, 1'b0, 32'h0,        1'b0, 32'h0,      1'b0, 4'b0000, 32'h0};
        tbl[1]  = '{4'b0011, 4'b0010, 1'b0, 32'h0,        1'b1, 32'h1000,   1'b0, 4'b0000, 32'h0};
        tbl[2]  = '{4'b0011, 4'b0010, 1'b1, 32'h11111111, 1'b0, 32'h0,      1'b0, 4'b0000, 32'h0};
        tbl[3]  = '{4'b0011, 4'b0010, 1'b0, 32'h0,        1'b0, 32'h0,      1'b0, 4'b0001, 32'h11111111};
        tbl[4]  = '{4'b0010, 4'b0010, 1'b0, 32'h0,        1'b0, 32'h0,      1'b0, 4'b0000, 32'h0};
        tbl[5]  = '{4'b0010, 4'b0010, 1'b0, 32'h0,        1'b1, 32'h1100,   1'b1, 4'b0000, 32'h0};
        tbl[6]  = '{4'b0010, 4'b0010, 1'b1, 32'h22222222, 1'b0, 32'h0,      1'b0, 4'b0000, 32'h0};
        tbl[7]  = '{4'b0010, 4'b0010, 1'b0, 32'h0,        1'b0, 32'h0,      1'b0, 4'b0010, 32'h0};
        tbl[8]  = '{4'b0001, 4'b0000, 1'b0, 32'h0,        1'b0, 32'h0,      1'b0, 4'b0000, 32'h0};
        tbl[9]  = '{4'b0001, 4'b0000, 1'b0, 32'h0,        1'b1, 32'h1000,   1'b0, 4'b0000, 32'h0};
        tbl[10] = '{4'b0001, 4'b0000, 1'b1, 32'h0BEEFA55, 1'b0, 32'h0,      1'b0, 4'b0000, 32'h0};
        tbl[11] = '{4'b0001, 4'b0000, 1'b0, 32'h0,        1'b0, 32'h0,      1'b0, 4'b0001, 32'h0BEEFA55};
        tbl[12] = '{4'b0000, 4'b0000, 1'b0, 32'h0,        1'b0, 32'h0,      1'b0, 4'b0000, 32'h0};
        tbl[13] = '{4'b0000, 4'b0000, 1'b1, 32'hDEADDEAD, 1'b0, 32'h0,      1'b0, 4'b0000, 32'h0};
        tbl[14] = '{4'b0000, 4'b0000, 1'b0, 32'h0,        1'b0, 32'h0,      1'b0, 4'b0000, 32'h0};
        tbl[15] = '{4'b0000, 4'b0000, 1'b0, 32'h0,        1'b0, 32'h0,      1'b0, 4'b0000, 32'h0};

        do_reset();

        // Contention from reset, single read with known latency, stray completion in IDLE.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            req         = tbl[i].req;
            rw          = tbl[i].rw;
            cache_valid = tbl[i].cv;
            cache_rdata = tbl[i].crd;
            chk($sformatf("vec%0d_creq", i), 64'(cache_request), 64'(tbl[i].e_creq));
            chk($sformatf("vec%0d_valid", i), 64'(valid), 64'(tbl[i].e_valid));
            if (tbl[i].e_creq) begin
                chk($sformatf("vec%0d_caddr", i), 64'(cache_addr), 64'(tbl[i].e_addr));
                chk($sformatf("vec%0d_crw", i), 64'(cache_rw), 64'(tbl[i].e_rw));
            end
            if (tbl[i].e_valid != '0)
                chk($sformatf("vec%0d_rdata", i), 64'(rdata), 64'(tbl[i].e_rdata));
        end
        cache_valid = 1'b0;

        // Round robin with every requester asserting continuously.
        rw = 4'b0000;
        do_reset();
        req = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            run_txn(0, 1'b1, 32'hA0 + 32'(t), v, e, rd, a);
            one = 4'b0001 << (t % NREQ);
            chk($sformatf("rr%0d_valid", t), 64'(v), 64'(one));
            chk($sformatf("rr%0d_addr", t), 64'(a), 64'(32'h1000 + 32'(t % NREQ) * 32'h100));
            chk($sformatf("rr%0d_rdata", t), 64'(rd), 64'(32'hA0 + 32'(t)));
            chk($sformatf("rr%0d_err", t), 64'(e), 64'h0);
        end

        // Late completion: ten idle WAIT cycles, then exactly one valid pulse.
        req = 4'b0001;
        run_txn(10, 1'b1, 32'hCAFE0000, v, e, rd, a);
        req = 4'b0000;
        chk("late_valid", 64'(v), 64'h1);
        chk("late_rdata", 64'(rd), 64'hCAFE0000);
        chk("late_addr", 64'(a), 64'h1000);
        @(negedge clk);
        chk("late_single_pulse", 64'(valid), 64'h0);

        // Write through the sequence task: write data forwarded, rdata forced to zero.
        rw  = 4'b0100;
        req = 4'b0100;
        run_txn(1, 1'b1, 32'h55555555, v, e, rd, a);
        req = 4'b0000;
        chk("wr_valid", 64'(v), 64'h4);
        chk("wr_rdata", 64'(rd), 64'h0);
        chk("wr_cwdata", 64'(cache_wdata), 64'hD002);
        chk("wr_crw", 64'(cache_rw), 64'h1);
        rw = 4'b0000;

        // Reset during WAIT abandons the transaction; the next grant restarts at requester 0.
        req = 4'b0110;
        begin
            bit got = 1'b0;
            for (int n = 0; n < 20 && !got; n++) begin
                @(negedge clk);
                got = cache_request;
            end
            chk("midwait_issue_seen", 64'(got), 64'h1);
        end
        @(negedge clk);
        do_reset();
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("post_rst_no_valid", 64'(valid), 64'h0);
            chk("post_rst_no_creq", 64'(cache_request), 64'h0);
        end
        req = 4'b1111;
        run_txn(0, 1'b1, 32'h77, v, e, rd, a);
        req = 4'b0000;
        chk("post_rst_grant", 64'(v), 64'h1);
        chk("post_rst_addr", 64'(a), 64'h1000);

`ifdef ARB_TIMEOUT_EN
        // Cache never answers: watchdog completes with err, then normal service resumes.
        @(negedge clk);
        req = 4'b0001;
        run_txn(0, 1'b0, 32'h0, v, e, rd, a);
        req = 4'b0000;
        chk("to_valid", 64'(v), 64'h1);
        chk("to_err", 64'(e), 64'h1);
        chk("to_rdata", 64'(rd), 64'h0);
        req = 4'b0010;
        run_txn(0, 1'b1, 32'h1234, v, e, rd, a);
        req = 4'b0000;
        chk("after_to_valid", 64'(v), 64'h2);
        chk("after_to_err", 64'(e), 64'h0);
        chk("after_to_rdata", 64'(rd), 64'h1234);
`endif

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got hang expected completion");
        $fatal(1, "timeout");
    end

endmodule
